// File: rtl/opcode_scheduler_if.sv
// Handshake bundle between the requesters, the opcode scheduler and the
// GF(2^m) multiply/XOR datapath.
interface opcode_scheduler_if #(
   parameter int DATA = 32
);
   logic [1:0]      req;
   logic            req_kind_0;
   logic            req_kind_1;
   logic [2:0]      req_size_0;
   logic [2:0]      req_size_1;
   logic [1:0]      gnt;
   logic [1:0]      done;
   logic            err;
   logic [DATA-1:0] opcode;
   logic            opcode_valid;
   logic            opcode_ready;
   logic            dp_idle;

   // scheduler side: serves requests and masters the opcode stream
   modport master (
      input  req, req_kind_0, req_kind_1, req_size_0, req_size_1,
      input  opcode_ready, dp_idle,
      output gnt, done, err, opcode, opcode_valid
   );

   // requester/datapath side
   modport slave (
      output req, req_kind_0, req_kind_1, req_size_0, req_size_1,
      output opcode_ready, dp_idle,
      input  gnt, done, err, opcode, opcode_valid
   );
endinterface

// File: rtl/opcode_scheduler.sv
// Round-robin scheduler for the shared GF(2^m) multiply/XOR datapath.
// Grants one of two requesters, streams the operation's opcode words under
// valid/ready, waits for the datapath to drain, then pulses done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant; arbitrate on req each cycle
// S_ISSUE | opcode_valid high, presenting word for r_step
// S_DRAIN | all words accepted, waiting for dp_idle
// S_DONE  | one cycle: done (and err for an illegal size) on the grant
//
// DATA must be at least 12 (opcode words occupy bits [11:0]).
module opcode_scheduler #(
   parameter int DATA = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   opcode_scheduler_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state, w_state;
   logic            r_last,  w_last;
   logic            r_g,     w_g;
   logic            r_kind,  w_kind;
   logic [2:0]      r_size,  w_size;
   logic [2:0]      r_step,  w_step;
   logic [1:0]      r_gnt,   w_gnt;
   logic [1:0]      r_done,  w_done;
   logic            r_err,   w_err;
   logic [DATA-1:0] r_opcode, w_opcode;
   logic            r_valid, w_valid;

   logic            w_pick;
   logic            w_pkind;
   logic [2:0]      w_psize;
   logic            w_legal;

   // Multiply words come from the datapath's opcode list; XOR words are
   // composed from their fields.
   function automatic logic [DATA-1:0] f_opcode(input logic kind, input logic [2:0] k);
      logic [11:0]     w;
      logic [DATA-1:0] o;
      w = '0;
      if (kind) begin
         w[10:9] = k[1:0] - 2'd1;
         w[8:6]  = 3'b111;
         w[5:4]  = 2'b10;
         w[2:0]  = {k[1:0] - 2'd1, 1'b0};
      end else begin
         case (k)
            3'd1:    w = 12'h028;
            3'd2:    w = 12'h098;
            3'd3:    w = 12'h0D2;
            3'd4:    w = 12'h11A;
            3'd5:    w = 12'h164;
            default: w = 12'h000;
         endcase
      end
      o        = '0;
      o[11:0]  = w;
      return o;
   endfunction

   // With both requesting, favour the one not granted last.
   assign w_pick  = (bus.req == 2'b11) ? ~r_last : bus.req[1];
   assign w_pkind = w_pick ? bus.req_kind_1 : bus.req_kind_0;
   assign w_psize = w_pick ? bus.req_size_1 : bus.req_size_0;
   assign w_legal = (w_psize != 3'd0) &&
                    (w_pkind ? (w_psize <= 3'd3) : (w_psize <= 3'd5));

   // Next-state and next-output decode.
   always_comb begin
      w_state  = r_state;
      w_last   = r_last;
      w_g      = r_g;
      w_kind   = r_kind;
      w_size   = r_size;
      w_step   = r_step;
      w_gnt    = r_gnt;
      w_done   = 2'b00;
      w_err    = 1'b0;
      w_opcode = r_opcode;
      w_valid  = r_valid;
      case (r_state)
         S_IDLE: begin
            if (bus.req != 2'b00) begin
               w_g    = w_pick;
               w_kind = w_pkind;
               w_size = w_psize;
               w_step = 3'd1;
               w_gnt  = w_pick ? 2'b10 : 2'b01;
               if (w_legal) begin
                  w_state  = S_ISSUE;
                  w_valid  = 1'b1;
                  w_opcode = f_opcode(w_pkind, 3'd1);
               end else begin
                  w_state = S_DONE;
                  w_done  = w_pick ? 2'b10 : 2'b01;
                  w_err   = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (r_valid && bus.opcode_ready) begin
               if (r_step == r_size) begin
                  w_state  = S_DRAIN;
                  w_valid  = 1'b0;
                  w_opcode = '0;
               end else begin
                  w_step   = r_step + 3'd1;
                  w_opcode = f_opcode(r_kind, r_step + 3'd1);
               end
            end
         end
         S_DRAIN: begin
            if (bus.dp_idle) begin
               w_state = S_DONE;
               w_done  = r_gnt;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_gnt   = 2'b00;
            w_last  = r_g;
            w_step  = 3'd1;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset clears outputs without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_last   <= 1'b1;
         r_g      <= 1'b0;
         r_kind   <= 1'b0;
         r_size   <= 3'd0;
         r_step   <= 3'd1;
         r_gnt    <= 2'b00;
         r_done   <= 2'b00;
         r_err    <= 1'b0;
         r_opcode <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_last   <= w_last;
         r_g      <= w_g;
         r_kind   <= w_kind;
         r_size   <= w_size;
         r_step   <= w_step;
         r_gnt    <= w_gnt;
         r_done   <= w_done;
         r_err    <= w_err;
         r_opcode <= w_opcode;
         r_valid  <= w_valid;
      end
   end

   assign bus.gnt          = r_gnt;
   assign bus.done         = r_done;
   assign bus.err          = r_err;
   assign bus.opcode       = r_opcode;
   assign bus.opcode_valid = r_valid;

endmodule

// File: tb/tb_opcode_scheduler.sv
// Self-checking bench for opcode_scheduler: a transaction-level model
// (queue of expected opcode words per grant) is compared against the DUT
// every falling edge, plus hand-computed checks on logs of what the DUT did.
module tb_opcode_scheduler;
   localparam int DATA = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   opcode_scheduler_if #(.DATA(DATA)) ifc();

   opcode_scheduler #(.DATA(DATA)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   int              mul_words[5] = '{'h028, 'h098, 'h0D2, 'h11A, 'h164};
   logic [1:0]      m_gnt   = '0;
   logic [1:0]      m_done  = '0;
   logic            m_err   = 1'b0;
   logic            m_valid = 1'b0;
   logic [DATA-1:0] m_op    = '0;
   int              m_phase = 0;   // 0 free, 1 words pending, 2 waiting for idle
   int              m_g     = 0;
   int              m_last  = 1;
   int              m_ops[$];

   function automatic int word_of(input int kind, input int k);
      if (kind == 1) return ((k - 1) << 9) | (7 << 6) | (2 << 4) | (2 * (k - 1));
      return mul_words[k-1];
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_gnt = '0; m_done = '0; m_err = 0; m_valid = 0; m_op = '0;
         m_phase = 0; m_last = 1; m_ops.delete();
      end else if (m_done != 0) begin
         m_last = m_g; m_done = '0; m_err = 0; m_gnt = '0;
      end else if (m_gnt == 0) begin
         if (ifc.req != 0) begin
            int kind, size;
            bit legal;
            if (ifc.req == 2'b11) m_g = (m_last == 0) ? 1 : 0;
            else                  m_g = ifc.req[1] ? 1 : 0;
            kind  = (m_g == 1) ? int'(ifc.req_kind_1) : int'(ifc.req_kind_0);
            size  = (m_g == 1) ? int'(ifc.req_size_1) : int'(ifc.req_size_0);
            legal = (size >= 1) && (size <= ((kind == 1) ? 3 : 5));
            m_gnt = (m_g == 1) ? 2'b10 : 2'b01;
            if (legal) begin
               m_ops.delete();
               for (int k = 1; k <= size; k++) m_ops.push_back(word_of(kind, k));
               m_valid = 1; m_op = DATA'(m_ops[0]); m_phase = 1;
            end else begin
               m_done = m_gnt; m_err = 1;
            end
         end
      end else if (m_phase == 1) begin
         if (ifc.opcode_ready) begin
            void'(m_ops.pop_front());
            if (m_ops.size() == 0) begin
               m_valid = 0; m_op = '0; m_phase = 2;
            end else begin
               m_op = DATA'(m_ops[0]);
            end
         end
      end else if (m_phase == 2) begin
         if (ifc.dp_idle) begin
            m_done = m_gnt; m_phase = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      chk("gnt",          64'(ifc.gnt),          64'(m_gnt));
      chk("done",         64'(ifc.done),         64'(m_done));
      chk("err",          64'(ifc.err),          64'(m_err));
      chk("opcode_valid", 64'(ifc.opcode_valid), 64'(m_valid));
      chk("opcode",       64'(ifc.opcode),       64'(m_op));
   end

   // ---------------- logs of DUT activity ----------------
   int         acc_q[$];
   int         acc_cyc[$];
   int         gnt_log[$];
   int         done_cyc   = -1;
   int         err_n      = 0;
   logic [1:0] err_done   = '0;
   logic [1:0] err_gnt    = '0;
   int         gnt_cycles = 0;
   bit         valid_seen = 0;
   logic [1:0] prev_gnt   = '0;

   initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         prev_gnt = '0;
      end else begin
         if (ifc.opcode_valid && ifc.opcode_ready) begin
            acc_q.push_back(int'(ifc.opcode));
            acc_cyc.push_back(cyc);
         end
         if (ifc.opcode_valid) valid_seen = 1;
         if (ifc.done != 0) done_cyc = cyc;
         if (ifc.err) begin
            err_n++; err_done = ifc.done; err_gnt = ifc.gnt;
         end
         if (ifc.gnt != 0) gnt_cycles++;
         if (ifc.gnt != 0 && prev_gnt == 0) gnt_log.push_back(ifc.gnt[1] ? 1 : 0);
         prev_gnt = ifc.gnt;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic wait_done(input int who);
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (ifc.done[who]) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL done_timeout: requester %0d got no done within 60 cycles", who);
      end
      ifc.req[who] = 1'b0;
      tick();
   endtask

   function automatic int acc_at(input int i);
      if (i < acc_q.size()) return acc_q[i];
      return -1;
   endfunction

   function automatic int last_acc_cyc();
      if (acc_cyc.size() > 0) return acc_cyc[acc_cyc.size()-1];
      return -100;
   endfunction

   task automatic clear_logs();
      acc_q.delete(); acc_cyc.delete(); gnt_log.delete();
      done_cyc = -1; err_n = 0; err_done = '0; err_gnt = '0;
      gnt_cycles = 0; valid_seen = 0;
   endtask

   // ---------------- directed tests ----------------
   int exp_mul[5] = '{'h028, 'h098, 'h0D2, 'h11A, 'h164};
   int exp_xor[3] = '{'h1E0, 'h3E2, 'h5E4};
   bit rdy_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   int exp_alt[4] = '{0, 1, 0, 1};

   initial begin
      ifc.req = 2'b00;
      ifc.req_kind_0 = 0; ifc.req_kind_1 = 0;
      ifc.req_size_0 = 0; ifc.req_size_1 = 0;
      ifc.opcode_ready = 1; ifc.dp_idle = 1;
      tick(3);
      chk("reset_gnt",   64'(ifc.gnt),          64'd0);
      chk("reset_valid", 64'(ifc.opcode_valid), 64'd0);
      rst_n = 1;
      tick();

      // multiply size 5, ready and idle high
      clear_logs();
      ifc.req_kind_0 = 0; ifc.req_size_0 = 5; ifc.req = 2'b01;
      wait_done(0);
      chk("mul5_count", 64'(acc_q.size()), 64'd5);
      for (int i = 0; i < 5; i++) chk("mul5_word", 64'(acc_at(i)), 64'(exp_mul[i]));
      chk("mul5_consecutive", 64'(last_acc_cyc() - acc_cyc[0]), 64'd4);
      chk("mul5_done_lat", 64'(done_cyc - last_acc_cyc()), 64'd2);
      chk("mul5_gnt_clear", 64'(ifc.gnt), 64'd0);

      // XOR size 3 with ready toggling
      clear_logs();
      ifc.req_kind_1 = 1; ifc.req_size_1 = 3; ifc.req = 2'b10;
      tick();
      for (int i = 0; i < 5; i++) begin
         ifc.opcode_ready = rdy_pat[i];
         tick();
      end
      ifc.opcode_ready = 1;
      wait_done(1);
      chk("xor3_count", 64'(acc_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) chk("xor3_word", 64'(acc_at(i)), 64'(exp_xor[i]));

      // both requesters holding req from reset
      rst_n = 0;
      ifc.req_kind_0 = 0; ifc.req_size_0 = 2;
      ifc.req_kind_1 = 1; ifc.req_size_1 = 1;
      ifc.req = 2'b11;
      tick();
      clear_logs();
      rst_n = 1;
      for (int i = 0; i < 80 && gnt_log.size() < 4; i++) tick();
      ifc.req = 2'b00;
      for (int i = 0; i < 20 && ifc.gnt != 0; i++) tick();
      tick(2);
      chk("rr_grants", 64'(gnt_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < gnt_log.size(); i++)
         chk("rr_order", 64'(gnt_log[i]), 64'(exp_alt[i]));

      // XOR size 4 (illegal)
      clear_logs();
      ifc.req_kind_0 = 1; ifc.req_size_0 = 4; ifc.req = 2'b01;
      wait_done(0);
      chk("xor4_err_n",   64'(err_n),      64'd1);
      chk("xor4_err_done",64'(err_done),   64'd1);
      chk("xor4_err_gnt", 64'(err_gnt),    64'd1);
      chk("xor4_gnt_cyc", 64'(gnt_cycles), 64'd1);
      chk("xor4_no_valid",64'(valid_seen), 64'd0);

      // multiply size 0 (illegal) on requester 1
      clear_logs();
      ifc.req_kind_1 = 0; ifc.req_size_1 = 0; ifc.req = 2'b10;
      wait_done(1);
      chk("mul0_err_n",   64'(err_n),      64'd1);
      chk("mul0_err_done",64'(err_done),   64'd2);
      chk("mul0_gnt_cyc", 64'(gnt_cycles), 64'd1);
      chk("mul0_no_valid",64'(valid_seen), 64'd0);

      // dp_idle low for 7 cycles after the last accept
      clear_logs();
      ifc.dp_idle = 0;
      ifc.req_kind_0 = 0; ifc.req_size_0 = 1; ifc.req = 2'b01;
      tick();
      tick();
      tick(7);
      chk("drain_hold_done",  64'(ifc.done),         64'd0);
      chk("drain_hold_valid", 64'(ifc.opcode_valid), 64'd0);
      ifc.dp_idle = 1;
      wait_done(0);
      chk("drain_done_lat", 64'(done_cyc - last_acc_cyc()), 64'd9);

      // async reset in step 3 of multiply size 4
      clear_logs();
      ifc.req_kind_0 = 0; ifc.req_size_0 = 4; ifc.req = 2'b01;
      tick(3);
      chk("rst_pre_word", 64'(ifc.opcode), 64'h0D2);
      #1 rst_n = 0;
      #1;
      chk("rst_async_valid",  64'(ifc.opcode_valid), 64'd0);
      chk("rst_async_gnt",    64'(ifc.gnt),          64'd0);
      chk("rst_async_opcode", 64'(ifc.opcode),       64'd0);
      ifc.req = 2'b00;
      tick(2);
      rst_n = 1;
      tick();
      clear_logs();
      ifc.req_size_0 = 1; ifc.req = 2'b01;
      wait_done(0);
      chk("restart_word", 64'(acc_at(0)), 64'h028);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
